// File: rtl/log_mul_pkg.sv
// Shared definitions for the log-multiplier arbiter: FSM encoding, FP16 constants and fields.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package log_mul_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int FP16_SIGN_W = 1;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MAN_W  = 10;
    localparam int FP16_W      = FP16_SIGN_W + FP16_EXP_W + FP16_MAN_W;

    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
    localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_MAN_W-1:0] man;
    } fp16_t;

    typedef struct packed {
        logic              id;
        logic              err;
        logic [FP16_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the one not served last.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant_vld,
    output logic       grant
);

    always_comb begin
        grant_vld = |req_valid;
        grant     = 1'b0;
        case (req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/log_mul_arbiter.sv
// Shares one FP16 log-multiplier core between two requesters; watchdog returns QNAN on a hung core.
// Latency: start 1 cycle after accept, response 1 cycle after core done (or TIMEOUT_CYCLES+2 on abort).
// Backpressure: response held until resp_ready; no request is accepted until the response retires.
module log_mul_arbiter
    import log_mul_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic [1:0]       req_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [15:0]      resp_data,
    output logic             resp_err,
    input  logic             resp_ready,
    output logic             mul_start,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic             mul_done,
    input  logic [15:0]      mul_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state;
    logic              last_grant;
    logic [15:0]       op_a;
    logic [15:0]       op_b;
    logic [7:0]        timer;
    resp_t             resp_q;
    logic [CNT_W-1:0]  count_q;
    logic              grant_vld;
    logic              grant;

    rr_arb2 u_rr_arb2 (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant_vld  (grant_vld),
        .grant      (grant)
    );

    // The arbiter only ever grants a requester whose valid is high, so a grant is a handshake.
    always_comb begin
        req_ready = 2'b00;
        if (state == ST_IDLE && grant_vld)
            req_ready = grant ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            timer      <= '0;
            resp_q     <= '0;
            count_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        op_a      <= grant ? req_a[31:16] : req_a[15:0];
                        op_b      <= grant ? req_b[31:16] : req_b[15:0];
                        resp_q.id <= grant;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the last watchdog cycle still counts as a real result.
                    if (mul_done) begin
                        resp_q.data <= mul_result;
                        resp_q.err  <= 1'b0;
                        state       <= ST_RESP;
                    end else if (timer == TIMER_LAST) begin
                        resp_q.data <= FP16_QNAN;
                        resp_q.err  <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
                    if (resp_ready) begin
                        last_grant <= resp_q.id;
                        count_q    <= count_q + CNT_W'(1);
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign mul_start  = (state == ST_ISSUE);
    assign mul_a      = op_a;
    assign mul_b      = op_b;
    assign resp_valid = (state == ST_RESP);
    assign resp_id    = resp_q.id;
    assign resp_data  = resp_q.data;
    assign resp_err   = resp_q.err;
    assign busy       = (state != ST_IDLE);
    assign op_count   = count_q;

endmodule

// File: tb/tb_log_mul_arbiter.sv
// Scoreboard bench for log_mul_arbiter with a mock multiplier core of programmable latency.
`timescale 1ns/1ps
module tb_log_mul_arbiter;
    import log_mul_pkg::*;

    localparam int TIMEOUT_CYCLES = 15;
    localparam int CNT_W          = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [1:0]       req_ready;
    logic             resp_valid;
    logic             resp_id;
    logic [15:0]      resp_data;
    logic             resp_err;
    logic             resp_ready = 1'b1;
    logic             mul_start;
    logic [15:0]      mul_a;
    logic [15:0]      mul_b;
    logic             mul_done = 1'b0;
    logic [15:0]      mul_result = '0;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    log_mul_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_err(resp_err), .resp_ready(resp_ready),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    typedef struct {
        logic        id;
        logic        err;
        logic [15:0] data;
        int          lat;
    } sb_t;

    sb_t  sb[$];
    logic grant_log[$];

    // mock core: 0 = a^b, 1 = fixed value, 2 = never completes
    int          mock_mode = 0;
    int          mock_lat = 5;
    logic [15:0] mock_fixed = '0;
    int          mock_cnt = 0;
    logic [15:0] mock_a = '0;
    logic [15:0] mock_b = '0;
    logic        stray_req = 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        mul_done = 1'b0;
        if (stray_req) begin
            mul_done   = 1'b1;
            mul_result = 16'hDEAD;
            stray_req  = 1'b0;
        end else if (mul_start) begin
            mock_cnt = mock_lat;
            mock_a   = mul_a;
            mock_b   = mul_b;
        end else if (mock_cnt > 0) begin
            mock_cnt--;
            if (mock_cnt == 0 && mock_mode != 2) begin
                mul_done   = 1'b1;
                mul_result = (mock_mode == 1) ? mock_fixed : (mock_a ^ mock_b);
            end
        end
    end

    // reference model state
    logic             m_busy = 1'b0;
    logic             m_last = 1'b1;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             prev_rv = 1'b0;
    int               hs_cyc = -100;
    int               resp_hs_cyc = -100;
    logic             expect_b2b = 1'b0;
    logic [15:0]      pend_a = '0;
    logic [15:0]      pend_b = '0;
    logic [1:0]       exp_rdy;
    logic             g;
    sb_t              e;
    sb_t              cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_busy      = 1'b0;
            m_last      = 1'b1;
            m_cnt       = '0;
            prev_rv     = 1'b0;
            hs_cyc      = -100;
            resp_hs_cyc = -100;
        end else begin
            exp_rdy = m_busy ? 2'b00 : model_grant(req_valid, m_last);
            check("req_ready", req_ready, exp_rdy);
            check("busy", busy, m_busy);
            check("mul_start", mul_start, m_busy && (cyc == hs_cyc + 1));
            check("op_count", op_count, m_cnt);
            if (!m_busy) check("resp_valid_idle", resp_valid, 0);
            if (mul_start) begin
                check("mul_a", mul_a, pend_a);
                check("mul_b", mul_b, pend_b);
            end

            if ((req_valid & req_ready) != 2'b00) begin
                g      = req_ready[1];
                pend_a = g ? req_a[31:16] : req_a[15:0];
                pend_b = g ? req_b[31:16] : req_b[15:0];
                e.id   = g;
                case (mock_mode)
                    0: begin e.data = pend_a ^ pend_b; e.err = 1'b0; e.lat = 2 + mock_lat; end
                    1: begin e.data = mock_fixed;      e.err = 1'b0; e.lat = 2 + mock_lat; end
                    default: begin e.data = FP16_QNAN; e.err = 1'b1; e.lat = 2 + TIMEOUT_CYCLES; end
                endcase
                sb.push_back(e);
                grant_log.push_back(g);
                if (expect_b2b && resp_hs_cyc >= 0) check("b2b_grant_cycle", cyc, resp_hs_cyc + 1);
                hs_cyc = cyc;
                m_busy = 1'b1;
            end

            if (resp_valid) begin
                if (!prev_rv) begin
                    if (sb.size() == 0) begin
                        check("sb_empty", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        check("resp_latency", cyc - hs_cyc, cur.lat);
                    end
                end
                check("resp_id", resp_id, cur.id);
                check("resp_data", resp_data, cur.data);
                check("resp_err", resp_err, cur.err);
                if (resp_ready) begin
                    m_last      = cur.id;
                    m_cnt       = m_cnt + 1'b1;
                    m_busy      = 1'b0;
                    resp_hs_cyc = cyc;
                    prev_rv     = 1'b0;
                end else begin
                    prev_rv = 1'b1;
                end
            end else begin
                prev_rv = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_hs(input int id);
        int n = 0;
        #1;
        while (!(req_valid[id] && req_ready[id]) && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 60) check("hs_timeout", 1, 0);
        step(1);
    endtask

    task automatic wait_resp();
        int n = 0;
        while (!resp_valid && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 60) check("resp_timeout", 1, 0);
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (op_count != CNT_W'(target) && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        check("op_count_reach", op_count, target);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_op_count"}, op_count, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_resp_id"}, resp_id, 0);
    endtask

    initial begin
        #3;
        check_outputs_zero("reset");
        step(1);
        rst_n = 1'b1;

        // single request, L=5
        mock_mode = 1; mock_lat = 5; mock_fixed = 16'h4000;
        req_a = {16'h0000, FP16_ONE}; req_b = {16'h0000, 16'h4000};
        req_valid = 2'b01;
        wait_hs(0);
        req_valid = 2'b00;
        wait_resp();
        step(1);
        check("single_count", op_count, 1);

        // contention from reset
        do_reset();
        grant_log.delete();
        mock_mode = 0; mock_lat = 3;
        req_a = {16'h4400, 16'h3C00}; req_b = {16'h4500, 16'h3800};
        expect_b2b = 1'b1;
        req_valid = 2'b11;
        wait_cnt(4);
        req_valid = 2'b00;
        expect_b2b = 1'b0;
        check("grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("grant0", grant_log[0], 0);
            check("grant1", grant_log[1], 1);
            check("grant2", grant_log[2], 0);
            check("grant3", grant_log[3], 1);
        end

        // backpressure: response held 10 cycles with both requesters pending
        mock_lat = 2;
        req_a = {16'h1234, 16'h5678}; req_b = {16'h0F0F, 16'hF0F0};
        resp_ready = 1'b0;
        req_valid = 2'b11;
        wait_hs(0);
        wait_resp();
        step(10);
        check("bp_still_valid", resp_valid, 1);
        expect_b2b = 1'b1;
        resp_ready = 1'b1;
        wait_hs(1);
        req_valid = 2'b00;
        wait_cnt(6);
        expect_b2b = 1'b0;

        // timeout, then a stray done in IDLE
        mock_mode = 2;
        req_a = {16'h0000, 16'h4000}; req_b = {16'h0000, 16'h4000};
        req_valid = 2'b01;
        wait_hs(0);
        req_valid = 2'b00;
        wait_resp();
        step(2);
        stray_req = 1'b1;
        step(5);
        check("stray_count", op_count, 7);

        // done lands on the final watchdog cycle
        mock_mode = 1; mock_lat = 15; mock_fixed = 16'h4200;
        req_a = {16'h3C00, 16'h0000}; req_b = {16'h4200, 16'h0000};
        req_valid = 2'b10;
        wait_hs(1);
        req_valid = 2'b00;
        wait_cnt(8);

        // async reset during WAIT
        mock_mode = 0; mock_lat = 10;
        req_a = {16'h0000, 16'h2222}; req_b = {16'h0000, 16'h1111};
        req_valid = 2'b01;
        wait_hs(0);
        req_valid = 2'b00;
        step(3);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        #8 rst_n = 1'b1;
        step(15);
        check("post_reset_count", op_count, 0);
        mock_lat = 4;
        req_a = {16'h3C00, 16'h0000}; req_b = {16'h4400, 16'h0000};
        req_valid = 2'b10;
        wait_hs(1);
        req_valid = 2'b00;
        wait_cnt(1);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/log_mul_arbiter.md
Name: log_mul_arbiter

Overview:
Shares one FP16 logarithmic approximate multiplier core between two requesters using round-robin arbitration.
- Accepts an operand pair through a valid/ready handshake, issues a one-cycle start pulse to the core and waits for its done pulse.
- Returns the result to the winning requester with an ID tag.
- A watchdog returns canonical NaN with an error flag if the core never completes.
- Sits between the host-side byte-collection logic and the multiplier datapath.

Parameters:
TIMEOUT_CYCLES, 15, max cycles spent in WAIT before abort; legal range 2..255.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester request valid; bit i = requester i
req_a  input  32  operands A, FP16; requester i at [16*i +: 16]
req_b  input  32  operands B, FP16; requester i at [16*i +: 16]
req_ready  output  2  per-requester accept; at most one bit high
resp_valid  output  1  response available
resp_id  output  1  requester that owns the response
resp_data  output  16  FP16 product
resp_err  output  1  response produced by timeout
resp_ready  input  1  consumer accepts response
mul_start  output  1  one-cycle start pulse to core
mul_a  output  16  operand A to core, stable from start until done or abort
mul_b  output  16  operand B to core, stable from start until done or abort
mul_done  input  1  core completion pulse
mul_result  input  16  core product, valid when mul_done=1
busy  output  1  high in any state except IDLE
op_count  output  CNT_W  completed responses (normal and error), wraps

Behaviour:
- Reset (async assert, sync release) clears all registers:
  - outputs 0; state IDLE.
  - last_grant=1, so requester 0 wins first.
  - Reset mid-operation drops the transaction silently; a later stray mul_done is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational and only driven in IDLE.
  - If exactly one req_valid bit is high, that requester is granted.
  - If both are high, grant !last_grant.
  - req_ready[g]=1 in that same cycle; the handshake occurs when req_valid[g]&req_ready[g].
  - On handshake, latch req_a/req_b slice into op_a/op_b, latch id=g, go ISSUE.
  - No valid request: stay in IDLE, req_ready=0.
- ISSUE: mul_start=1 for exactly this cycle; mul_a/mul_b=op_a/op_b; timer cleared; go WAIT.
- WAIT:
  - If mul_done: capture mul_result, resp_err=0, go RESP.
  - Else if timer==TIMEOUT_CYCLES-1: resp_data=16'h7E00, resp_err=1, go RESP.
  - Else timer++.
  - mul_done and the timeout condition in the same cycle: done wins.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err are held stable until resp_ready.
  - On resp_valid&resp_ready: last_grant=id, op_count++ (wraps at 2^CNT_W), go IDLE.
  - resp_valid falls the next cycle. No same-cycle re-accept; the next grant is earliest one cycle after the response handshake.
- mul_done seen outside WAIT is ignored.
- mul_a/mul_b hold the last latched operands in every state (no X, no zeroing).
- Latency, request handshake at cycle 0 and core done on cycle 1+L:
  - mul_start at cycle 1.
  - resp_valid from cycle 2+L.
  - Timeout response from cycle 2+TIMEOUT_CYCLES.
- A request held valid while the other requester is being served waits; no starvation, because grants alternate whenever both are pending.

Decomposition:
- Shared package log_mul_pkg:
  - FSM state encoding (2-bit).
  - FP16 constants: FP16_QNAN=16'h7E00, FP16_ONE=16'h3C00.
  - FP16 field widths: 1 sign / 5 exponent / 10 mantissa.
- Sub-module rr_arb2: 2-input round-robin grant from req_valid and last_grant. Combinational, about 15 lines.
- Everything else stays in the top module.

Test Plan:
- Single request: requester 0, A=16'h3C00, B=16'h4000; mock core with L=5 returns 16'h4000 → mul_start at cycle 1, resp_valid at cycle 7, resp_id=0, resp_data=16'h4000, resp_err=0, op_count=1.
- Contention: both req_valid=1 from reset → grants in order 0,1,0,1 over four transactions; req_ready never has both bits high; op_count=4.
- Backpressure: hold resp_ready=0 for 10 cycles → resp_valid/resp_data stable throughout, req_ready=0, no second mul_start; one cycle after resp_ready=1, IDLE grants the next request.
- Timeout: mock core never asserts done, TIMEOUT_CYCLES=15 → resp_valid at cycle 17, resp_data=16'h7E00, resp_err=1; a late mul_done in IDLE is ignored.
- Done on the timeout cycle: mul_done asserted when timer=14 with result 16'h4200 → resp_data=16'h4200, resp_err=0.
- Async reset pulse during WAIT → all outputs 0 immediately; after release, a requester-1-only request is granted and completes normally.
